// File: rtl/id_stage_sb_if.sv
// Decode-to-execute pipeline bus: registered instruction, operands and destination,
// with a valid/ready handshake. The stage drives it as master, EX consumes as slave.
interface id_stage_sb_if #(
    parameter int WIDTH        = 32,
    parameter int PC_W         = WIDTH - 2,
    parameter int REG_ADDR_LEN = 5
);
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        IR_out;
    logic [PC_W-1:0]         PC_out;
    logic [WIDTH-1:0]        X;
    logic [WIDTH-1:0]        Y;
    logic [REG_ADDR_LEN-1:0] dst_out;
    logic                    dst_we;

    modport master (
        output out_valid, IR_out, PC_out, X, Y, dst_out, dst_we,
        input  out_ready
    );

    modport slave (
        input  out_valid, IR_out, PC_out, X, Y, dst_out, dst_we,
        output out_ready
    );
endinterface

// File: rtl/id_stage_sb.sv
// Decode/operand-fetch stage: field decode, register read with writeback bypass,
// per-register busy scoreboard for RAW/WAW stalls, and a valid/ready output register.
module id_stage_sb #(
    parameter int WIDTH        = 32,
    parameter int PC_W         = WIDTH - 2,
    parameter int REG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        IR_in,
    input  logic [PC_W-1:0]         PC_in,
    output logic [REG_ADDR_LEN-1:0] Rd1_addr,
    output logic [REG_ADDR_LEN-1:0] Rd2_addr,
    input  logic [WIDTH-1:0]        Rd1_data,
    input  logic [WIDTH-1:0]        Rd2_data,
    input  logic                    wb_en,
    input  logic [REG_ADDR_LEN-1:0] wb_addr,
    input  logic [WIDTH-1:0]        wb_data,
    input  logic                    flush,
    id_stage_sb_if.master           ex,
    output logic                    illegal,
    output logic                    halted
);
    localparam int NREGS = 2 ** REG_ADDR_LEN;

    typedef enum logic [5:0] {
        OP_NOP  = 6'h00,
        OP_R    = 6'h01,
        OP_I    = 6'h02,
        OP_LW   = 6'h03,
        OP_LH   = 6'h04,
        OP_LD   = 6'h05,
        OP_SW   = 6'h06,
        OP_SH   = 6'h07,
        OP_SD   = 6'h08,
        OP_BR   = 6'h09,
        OP_J    = 6'h0A,
        OP_HALT = 6'h3F
    } opcode_e;

    logic [NREGS-1:0]        busy, busy_nxt, wb_mask, eff_busy;
    logic [REG_ADDR_LEN-1:0] f_rd, f_rs, f_rt, a1, a2, dst;
    logic                    use1, use2, we, y_imm, x_tgt, is_halt, undef;
    logic [WIDTH-1:0]        op1, op2, x_nxt, y_nxt;
    logic                    hazard, accept;

    assign f_rd = REG_ADDR_LEN'(IR_in[25:21]);
    assign f_rs = REG_ADDR_LEN'(IR_in[20:16]);
    assign f_rt = REG_ADDR_LEN'(IR_in[15:11]);

    always_comb begin
        a1      = '0;
        a2      = '0;
        dst     = '0;
        use1    = 1'b0;
        use2    = 1'b0;
        we      = 1'b0;
        y_imm   = 1'b0;
        x_tgt   = 1'b0;
        is_halt = 1'b0;
        undef   = 1'b0;
        case (IR_in[31:26])
            OP_R: begin
                a1 = f_rs; a2 = f_rt; use1 = 1'b1; use2 = 1'b1; dst = f_rd; we = 1'b1;
            end
            OP_I, OP_LW, OP_LH, OP_LD: begin
                a1 = f_rs; use1 = 1'b1; y_imm = 1'b1; dst = f_rd; we = 1'b1;
            end
            OP_BR: begin
                a1 = f_rd; use1 = 1'b1; y_imm = 1'b1;
            end
            OP_SW, OP_SH, OP_SD: begin
                a1 = f_rd; a2 = f_rs; use1 = 1'b1; use2 = 1'b1;
            end
            OP_J:    x_tgt = 1'b1;
            OP_NOP:  ;
            OP_HALT: is_halt = 1'b1;
            default: undef = 1'b1;
        endcase
    end

    assign Rd1_addr = a1;
    assign Rd2_addr = a2;

    // Unused ports carry address 0, so they read as zero without extra gating.
    always_comb begin
        op1 = Rd1_data;
        if (a1 == '0)                   op1 = '0;
        else if (wb_en && wb_addr == a1) op1 = wb_data;
        op2 = Rd2_data;
        if (a2 == '0)                   op2 = '0;
        else if (wb_en && wb_addr == a2) op2 = wb_data;
        x_nxt = x_tgt ? {{(WIDTH-26){1'b0}}, IR_in[25:0]} : op1;
        y_nxt = y_imm ? {{(WIDTH-16){IR_in[15]}}, IR_in[15:0]} : op2;
    end

    always_comb begin
        wb_mask          = '0;
        wb_mask[wb_addr] = wb_en;
        eff_busy         = busy & ~wb_mask;
        hazard   = (use1 & eff_busy[a1]) | (use2 & eff_busy[a2]) | (we & eff_busy[dst]);
        in_ready = ~halted & ~flush & ~hazard & (~ex.out_valid | ex.out_ready);
        accept   = in_valid & in_ready;
    end

    // The flush-kill clear is suppressed when a writeback targets some other register
    // in the same cycle; set-on-accept is applied last so it wins over any clear.
    always_comb begin
        busy_nxt = busy & ~wb_mask;
        if (flush && ex.out_valid && ex.dst_we && !(wb_en && wb_addr != ex.dst_out))
            busy_nxt[ex.dst_out] = 1'b0;
        if (accept && we)
            busy_nxt[dst] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= '0;
            halted        <= 1'b0;
            illegal       <= 1'b0;
            ex.out_valid  <= 1'b0;
            ex.IR_out     <= '0;
            ex.IR_out[31:26] <= OP_NOP;
            ex.PC_out     <= '0;
            ex.X          <= '0;
            ex.Y          <= '0;
            ex.dst_out    <= '0;
            ex.dst_we     <= 1'b0;
        end else begin
            busy    <= busy_nxt;
            halted  <= halted | (accept & is_halt);
            illegal <= accept & undef;
            if (flush) begin
                ex.out_valid <= 1'b0;
            end else if (accept) begin
                ex.out_valid <= 1'b1;
                ex.IR_out    <= IR_in;
                ex.PC_out    <= PC_in;
                ex.X         <= x_nxt;
                ex.Y         <= y_nxt;
                ex.dst_out   <= dst;
                ex.dst_we    <= we;
            end else if (ex.out_ready) begin
                ex.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/id_stage_sb.md
Name: id_stage_sb

Overview:
- Parametrised decode/operand-fetch stage, the successor to the current fixed-width ID stage.
- Sits between IF and EX. Decodes the instruction, reads two register-file ports, and sign/zero-extends immediates.
- Detects RAW/WAW hazards with a per-register scoreboard, bypasses same-cycle writeback data, and hands the result to EX through a valid/ready pipeline register with flush and HALT support.

Parameters:
- WIDTH, 32, datapath width; X/Y/IR width.
- PC_W, WIDTH-2, PC width.
- REG_ADDR_LEN, 5, register address width; NREGS = 2**REG_ADDR_LEN.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  IF holds a valid instruction.
- in_ready  out  1  stage accepts IR_in/PC_in this cycle.
- IR_in  in  WIDTH  instruction.
- PC_in  in  PC_W  instruction PC.
- Rd1_addr, Rd2_addr  out  REG_ADDR_LEN  combinational register read addresses.
- Rd1_data, Rd2_data  in  WIDTH  same-cycle read data.
- wb_en  in  1  writeback this cycle.
- wb_addr  in  REG_ADDR_LEN  writeback register.
- wb_data  in  WIDTH  writeback data.
- flush  in  1  kill the instruction in the output register; accept nothing this cycle.
- out_valid  out  1  output register valid.
- out_ready  in  1  EX accepts the output.
- IR_out  out  WIDTH  registered instruction.
- PC_out  out  PC_W  registered PC.
- X, Y  out  WIDTH  registered operands.
- dst_out  out  REG_ADDR_LEN  destination register.
- dst_we  out  1  instruction writes dst_out.
- illegal  out  1  one-cycle pulse when an undefined opcode is accepted.
- halted  out  1  stage halted.

Behaviour:
- Instruction fields: OpCode[31:26], Rd[25:21], Rs[20:16], Rt[15:11], Imm[15:0], Tgt[25:0]. Opcode values come from the team ISA header.
- Operands and reads, by class:
  - R_TYPE: X=R[Rs], Y=R[Rt]; dst=Rd, we=1.
  - I_TYPE/LW/LH/LD: X=R[Rs], Y=sext(Imm); dst=Rd, we=1.
  - Branch: X=R[Rd], Y=sext(Imm); we=0.
  - SD/SH/SW: X=R[Rd], Y=R[Rs]; we=0.
  - J_TYPE: X=zext(Tgt), Y=0; we=0.
  - NOP/HALT/undefined: X=Y=0, we=0. Undefined opcodes also pulse illegal.
- Register 0 always reads 0 and is never busy.
- Bypass: if wb_en and wb_addr equals a source register, the operand takes wb_data instead of Rd*_data.
- Scoreboard busy[NREGS]:
  - eff_busy(r) = busy[r] & ~(wb_en & wb_addr==r).
  - hazard = any used source or dest (when we=1) with eff_busy.
- Handshake and acceptance:
  - in_ready = ~halted & ~flush & ~hazard & (~out_valid | out_ready).
  - accept = in_valid & in_ready. Outputs load at the next posedge; latency 1 cycle.
  - out_valid && !out_ready: every output holds stable.
  - Output consumed with no new accept: out_valid drops to 0.
- Busy updates, each posedge:
  - wb_en clears busy[wb_addr].
  - An accept with we=1 sets busy[dst]. If set and clear hit the same register, set wins.
- Flush:
  - out_valid goes to 0 next cycle.
  - If the killed instruction had dst_we=1, busy[dst_out] clears, unless wb_en targets a different register. The flush clear and a wb clear may coincide.
  - Nothing is accepted during flush. Flush has priority over out_ready.
- HALT: when HALT is accepted, halted rises with it. From then on in_ready=0 until rst; the HALT itself still drains via out_valid.
- Reset: out_valid=0, halted=0, illegal=0, busy all 0; IR_out=NOP, PC_out=0, X=Y=0, dst_out=0, dst_we=0. Reset mid-stall discards the held instruction.
- Arithmetic: sext replicates Imm[15] to WIDTH; zext pads Tgt with zeros. No truncation errors for WIDTH>=32.

Test Plan:
1. Reset 2 cycles with in_valid=1 -> out_valid=0, in_ready=1 after reset, busy all 0, outputs at reset values.
2. R1=5, R2=7; R_TYPE Rd=3,Rs=1,Rt=2 -> next cycle out_valid=1, X=5, Y=7, dst_out=3, dst_we=1, busy[3]=1.
3. After test 2, I_TYPE Rs=3, Imm=16'hFFFE -> in_ready=0 for 3 cycles. Then wb_en=1, wb_addr=3, wb_data=32'h2A -> accepted that cycle; next cycle X=32'h2A, Y=32'hFFFFFFFE.
4. out_ready=0 for 4 cycles with in_valid=1 -> IR_out/X/Y unchanged, in_ready=0. Raise out_ready -> the next instruction loads one cycle later.
5. Output holds R_TYPE dst=4; assert flush -> out_valid=0, busy[4]=0, in_ready=0 during flush. A following read of R4 proceeds without stall.
6. HALT followed by R_TYPE -> HALT output once, halted=1, in_ready stays 0 for 10 cycles. rst -> halted=0.
